// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU, the control unit and mul_div_unit.
//   MD_MUL / MD_DIV : mul_div_unit op select values
//   md_state_e      : mul_div_unit sequencer states
//   OP_MUL / OP_DIV : ALU op numbers whose results come from mul_div_unit
package alu_pkg;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  localparam int OP_MUL = 6;
  localparam int OP_DIV = 7;

endpackage

// File: rtl/twos_neg.sv
// twos_neg: combinational two's-complement conditional negate.
//   value  : input word
//   neg_en : 1 -> result = -value, 0 -> result = value
//   result : output word (same width; -2^(WIDTH-1) maps to itself, which is
//            the correct unsigned magnitude 2^(WIDTH-1))
// Feeding neg_en with the sign bit of value gives |value|.
module twos_neg #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg_en,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = neg_en ? (~value + WIDTH'(1)) : value;
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed multiply / divide, one bit per cycle.
//   clk, reset  : clock, synchronous active-high reset
//   start, op   : request pulse (sampled in IDLE only), 0 = multiply, 1 = divide
//   a, b        : two's-complement operands (multiplicand/dividend, multiplier/divisor)
//   busy        : high in RUN and FIX
//   done        : one-cycle pulse, hi/lo/div_by_zero valid in that cycle
//   hi, lo      : product upper/lower half, or remainder/quotient
//   div_by_zero : set with done for a divide with b == 0
// Multiply uses radix-2 Booth on a WIDTH+1 bit accumulator; divide runs a
// restoring divide on operand magnitudes followed by a sign fix-up.
module mul_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  // Multiply: sign-extended multiplicand. Divide: zero-extended divisor magnitude.
  logic [WIDTH:0]    mcand_q, mcand_d;
  // Multiply: Booth accumulator. Divide: partial remainder.
  logic [WIDTH:0]    acc_q, acc_d;
  // Multiply: multiplier / low product. Divide: dividend shifting into quotient.
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic              qm1_q, qm1_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic              bzero_q, bzero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]  a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH:0]    booth_sum;
  logic [WIDTH:0]    div_shift, div_diff;

  twos_neg #(.WIDTH(WIDTH)) u_abs_a (.value(a), .neg_en(a[WIDTH-1]), .result(a_mag));
  twos_neg #(.WIDTH(WIDTH)) u_abs_b (.value(b), .neg_en(b[WIDTH-1]), .result(b_mag));
  twos_neg #(.WIDTH(WIDTH)) u_fix_q (.value(quo_q), .neg_en(qsign_q), .result(quo_fix));
  twos_neg #(.WIDTH(WIDTH)) u_fix_r (.value(acc_q[WIDTH-1:0]), .neg_en(rsign_q), .result(rem_fix));

  // Booth add/subtract before the arithmetic shift.
  always_comb begin
    unique case ({quo_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + mcand_q;
      2'b10:   booth_sum = acc_q - mcand_q;
      default: booth_sum = acc_q;
    endcase
  end

  // Partial remainder stays below the divisor magnitude (<= 2^(WIDTH-1)), so
  // the shifted value fits in WIDTH bits and bit WIDTH of the difference is
  // a clean borrow flag.
  always_comb begin
    div_shift = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
    div_diff  = div_shift - mcand_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    qm1_d   = qm1_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    bzero_d = bzero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          cnt_d   = CNT_W'(WIDTH);
          acc_d   = '0;
          qm1_d   = 1'b0;
          bzero_d = (b == '0);
          busy_d  = 1'b1;
          state_d = MD_RUN;
          if (op == MD_DIV) begin
            quo_d   = a_mag;
            mcand_d = {1'b0, b_mag};
            qsign_d = a[WIDTH-1] ^ b[WIDTH-1];
            rsign_d = a[WIDTH-1];
          end else begin
            quo_d   = b;
            mcand_d = {a[WIDTH-1], a};
            qsign_d = 1'b0;
            rsign_d = 1'b0;
          end
        end
      end

      MD_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_FIX;
        end
        if (op_q == MD_DIV) begin
          if (div_diff[WIDTH]) begin
            acc_d = div_shift;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = div_diff;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          quo_d = {booth_sum[0], quo_q[WIDTH-1:1]};
          qm1_d = quo_q[0];
        end
      end

      MD_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = MD_DONE;
        if (op_q == MD_DIV) begin
          if (bzero_q) begin
            lo_d  = '1;
            hi_d  = a_q;
            dbz_d = 1'b1;
          end else begin
            lo_d  = quo_fix;
            hi_d  = rem_fix;
            dbz_d = 1'b0;
          end
        end else begin
          // After WIDTH Booth steps the product sits in {acc, quo}.
          lo_d  = quo_q;
          hi_d  = acc_q[WIDTH-1:0];
          dbz_d = 1'b0;
        end
      end

      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      a_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      qm1_q   <= 1'b0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      bzero_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      qm1_q   <= qm1_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      bzero_q <= bzero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit against an
// integer-arithmetic reference model.
module tb_mul_div_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic.
  function automatic void model(input logic mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] ehi, output logic [W-1:0] elo,
                                output logic edbz);
    int sa, sb, p, qq, rr;
    sa = $signed(ma);
    sb = $signed(mb);
    if (mop == 1'b0) begin
      p    = sa * sb;
      ehi  = p[2*W-1:W];
      elo  = p[W-1:0];
      edbz = 1'b0;
    end else if (sb == 0) begin
      ehi  = ma;
      elo  = '1;
      edbz = 1'b1;
    end else begin
      qq   = sa / sb;
      rr   = sa % sb;
      elo  = qq[W-1:0];
      ehi  = rr[W-1:0];
      edbz = 1'b0;
    end
  endfunction

  // Start one operation at the next falling edge (cycle 0) and wait for done.
  // With inject set, extra start pulses are driven in cycles 3 and W+2 and
  // start is left high on return (the caller clears it).
  task automatic do_op(input logic top, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input bit inject);
    logic [W-1:0] ehi, elo;
    logic         edbz;
    int           lat;
    bit           busy_ok;
    model(top, ta, tb_v, ehi, elo, edbz);
    @(negedge clk);
    start = 1'b1;
    op    = top;
    a     = ta;
    b     = tb_v;
    lat     = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= W + 12; n++) begin
      @(negedge clk);
      start = inject && (n == 3 || n == W + 2);
      if (start) begin
        op = ~top;
        a  = W'($urandom);
        b  = W'($urandom);
      end
      if (done) begin
        lat = n;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b latency=%0d (exp hi=%h lo=%h dbz=%b)",
             top, ta, tb_v, hi, lo, div_by_zero, lat, ehi, elo, edbz);
    check("latency", 32'(lat), 32'(W + 2));
    check("busy", 32'(busy_ok), 32'd1);
    check("hi", 32'(hi), 32'(ehi));
    check("lo", 32'(lo), 32'(elo));
    check("div_by_zero", 32'(div_by_zero), 32'(edbz));
  endtask

  // Idle for a number of cycles with start low: no done, no busy, hi/lo stable.
  task automatic watch_idle(input int cycles, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    bit done_seen, busy_seen, stable;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    stable    = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (hi !== ehi || lo !== elo) stable = 1'b0;
    end
    $display("idle %0d cycles: done_seen=%b busy_seen=%b stable=%b", cycles, done_seen, busy_seen, stable);
    check("idle_no_done", 32'(done_seen), 32'd0);
    check("idle_no_busy", 32'(busy_seen), 32'd0);
    check("idle_hilo_stable", 32'(stable), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ehi, elo;
    logic         edbz;
    logic         rop;
    logic [W-1:0] ra, rb;

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    $display("reset: busy=%b done=%b hi=%h lo=%h dbz=%b", busy, done, hi, lo, div_by_zero);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", 32'(hi), 32'd0);
    check("rst_lo", 32'(lo), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    // Directed cases, issued back to back (start in the cycle after done).
    do_op(1'b0, 8'd7,    8'hFD, 1'b0);
    do_op(1'b0, 8'h80,   8'h80, 1'b0);
    do_op(1'b0, 8'h80,   8'h01, 1'b0);
    do_op(1'b1, 8'hF9,   8'h02, 1'b0);
    do_op(1'b1, 8'h07,   8'hFE, 1'b0);
    do_op(1'b1, 8'h80,   8'hFF, 1'b0);
    do_op(1'b1, 8'h05,   8'h00, 1'b0);
    do_op(1'b1, 8'h09,   8'h04, 1'b0);
    do_op(1'b0, 8'h7F,   8'h80, 1'b0);
    do_op(1'b1, 8'h80,   8'h01, 1'b0);

    // Extra start pulses during RUN and DONE must be ignored.
    do_op(1'b0, 8'd12, 8'd11, 1'b1);
    model(1'b0, 8'd12, 8'd11, ehi, elo, edbz);
    watch_idle(15, ehi, elo);

    // Reset in the middle of a 7*3 multiply.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 8'd7;
    b     = 8'd3;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 4) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    $display("mid-op reset: busy=%b done=%b hi=%h lo=%h dbz=%b", busy, done, hi, lo, div_by_zero);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_hi", 32'(hi), 32'd0);
    check("midrst_lo", 32'(lo), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    watch_idle(20, 8'h00, 8'h00);
    do_op(1'b0, 8'd7, 8'd3, 1'b0);

    // Random operations, with a share of zero divisors.
    for (int i = 0; i < 60; i++) begin
      rop = 1'($urandom);
      ra  = W'($urandom);
      rb  = (($urandom % 8) == 0) ? '0 : W'($urandom);
      do_op(rop, ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
